dma_fifo_bridge: RTL and testbench



---
 rtl/dma_fifo_bridge.sv | 212 +++++++++++++++++++++
 tb/tb_dma_fifo_bridge.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_fifo_bridge.sv
// Avalon-MM FIFO with two PL330 peripheral request channels.
// TX asks for data while the FIFO has room; RX asks to be drained while it holds data.
module dma_fifo_bridge #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 64,
    parameter int BURST_LEN = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address_i,
    input  logic              write_i,
    input  logic [DATA_W-1:0] writedata_i,
    input  logic              read_i,
    output logic [DATA_W-1:0] readdata_o,
    output logic              tx_single_o,
    output logic              tx_burst_o,
    input  logic              tx_ack_i,
    output logic              rx_single_o,
    output logic              rx_burst_o,
    input  logic              rx_ack_i
);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] LVL_ZERO = LVL_W'(0);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] BURST_L  = LVL_W'(BURST_LEN);
    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } req_state_e;

    typedef struct packed {
        req_state_e state;
        logic       single;
        logic       burst;
    } req_t;

    localparam req_t REQ_RST = '{state: IDLE, single: 1'b0, burst: 1'b0};

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              tx_en_q, tx_en_d, rx_en_q, rx_en_d;
    logic [DATA_W-1:0] readdata_q, readdata_d;
    req_t              tx_q, tx_d, rx_q, rx_d;

    logic              empty_s, full_s;
    logic              data_wr_s, data_rd_s, ctrl_wr_s;
    logic              push_s, pop_s, flush_s, clr_s;
    logic [LVL_W-1:0]  free_s;
    logic [DATA_W-1:0] status_s;

    // A request is latched on entry to REQ and held untouched until acknowledged.
    function automatic req_t req_next(input req_t cur, input logic en,
                                      input logic ack, input logic [LVL_W-1:0] cond);
        req_t nxt;
        nxt = cur;
        case (cur.state)
            IDLE: begin
                if (en && (cond != LVL_ZERO)) begin
                    nxt.state  = REQ;
                    nxt.single = 1'b1;
                    nxt.burst  = (cond >= BURST_L);
                end else begin
                    nxt.single = 1'b0;
                    nxt.burst  = 1'b0;
                end
            end
            REQ: begin
                if (ack) begin
                    nxt.state  = ACK;
                    nxt.single = 1'b0;
                    nxt.burst  = 1'b0;
                end else begin
                    nxt.state  = REQ;
                end
            end
            ACK: begin
                nxt.single = 1'b0;
                nxt.burst  = 1'b0;
                if (!ack) begin
                    nxt.state = IDLE;
                end else begin
                    nxt.state = ACK;
                end
            end
            default: nxt = REQ_RST;
        endcase
        return nxt;
    endfunction

    assign empty_s   = (level_q == LVL_ZERO);
    assign full_s    = (level_q == DEPTH_L);
    assign free_s    = DEPTH_L - level_q;
    assign data_wr_s = write_i && (address_i == 2'd0);
    assign data_rd_s = read_i && !write_i && (address_i == 2'd0);
    assign ctrl_wr_s = write_i && (address_i == 2'd2);
    assign push_s    = data_wr_s && !full_s;
    assign pop_s     = data_rd_s && !empty_s;
    assign flush_s   = ctrl_wr_s && writedata_i[2];
    assign clr_s     = ctrl_wr_s && writedata_i[3];

    // Status word assembly.
    always_comb begin
        status_s              = {DATA_W{1'b0}};
        status_s[LVL_W-1:0]   = level_q;
        status_s[16]          = empty_s;
        status_s[17]          = full_s;
        status_s[18]          = ovf_q;
        status_s[19]          = unf_q;
    end

    // FIFO bookkeeping, sticky flags, enables and the registered read mux.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        readdata_d = {DATA_W{1'b0}};
        if (flush_s) begin
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
            level_d  = LVL_ZERO;
        end else if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            level_d  = level_q + LVL_ONE;
        end else if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            level_d  = level_q - LVL_ONE;
        end else begin
            level_d  = level_q;
        end
        if (clr_s) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else begin
            ovf_d = ovf_q | (data_wr_s & full_s);
            unf_d = unf_q | (data_rd_s & empty_s);
        end
        if (ctrl_wr_s) begin
            tx_en_d = writedata_i[0];
            rx_en_d = writedata_i[1];
        end else begin
            tx_en_d = tx_en_q;
            rx_en_d = rx_en_q;
        end
        // A simultaneous write wins; the read then returns zero.
        if (read_i && !write_i) begin
            case (address_i)
                2'd0:    readdata_d = pop_s ? mem_q[rd_ptr_q] : {DATA_W{1'b0}};
                2'd1:    readdata_d = status_s;
                2'd2:    readdata_d = {{(DATA_W-2){1'b0}}, rx_en_q, tx_en_q};
                default: readdata_d = {DATA_W{1'b0}};
            endcase
        end else begin
            readdata_d = {DATA_W{1'b0}};
        end
    end

    // Next state for both request channels.
    always_comb begin
        tx_d = REQ_RST;
        rx_d = REQ_RST;
        tx_d = req_next(tx_q, tx_en_q, tx_ack_i, free_s);
        rx_d = req_next(rx_q, rx_en_q, rx_ack_i, level_q);
    end

    // FIFO storage array.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= writedata_i;
        end
    end

    // Control, status and channel state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= PTR_ZERO;
            rd_ptr_q   <= PTR_ZERO;
            level_q    <= LVL_ZERO;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            tx_en_q    <= 1'b0;
            rx_en_q    <= 1'b0;
            readdata_q <= {DATA_W{1'b0}};
            tx_q       <= REQ_RST;
            rx_q       <= REQ_RST;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            tx_en_q    <= tx_en_d;
            rx_en_q    <= rx_en_d;
            readdata_q <= readdata_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
        end
    end

    assign readdata_o  = readdata_q;
    assign tx_single_o = tx_q.single;
    assign tx_burst_o  = tx_q.burst;
    assign rx_single_o = rx_q.single;
    assign rx_burst_o  = rx_q.burst;
endmodule

// File: tb/tb_dma_fifo_bridge.sv
// Scoreboard bench for dma_fifo_bridge (DEPTH=64, BURST_LEN=8, DATA_W=32).
module tb_dma_fifo_bridge;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic        tx_single, tx_burst, tx_ack;
    logic        rx_single, rx_burst, rx_ack;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    dma_fifo_bridge #(.DATA_W(32), .DEPTH(64), .BURST_LEN(8)) dut (
        .clk(clk), .reset(reset),
        .address_i(address), .write_i(write), .writedata_i(writedata),
        .read_i(read), .readdata_o(readdata),
        .tx_single_o(tx_single), .tx_burst_o(tx_burst), .tx_ack_i(tx_ack),
        .rx_single_o(rx_single), .rx_burst_o(rx_burst), .rx_ack_i(rx_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic av_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        tick();
        write = 1'b0; writedata = 32'h0;
    endtask

    task automatic av_read(input logic [1:0] a, output logic [31:0] d);
        address = a; read = 1'b1;
        tick();
        read = 1'b0;
        d = readdata;
    endtask

    task automatic push_word(input logic [31:0] d);
        exp_q.push_back(d);
        av_write(2'd0, d);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1; address = 2'd0; write = 1'b0; writedata = 32'h0;
        read = 1'b0; tx_ack = 1'b0; rx_ack = 1'b0;
        repeat (2) tick();
        checks++; if ({tx_single, tx_burst, rx_single, rx_burst} !== 4'b0000) begin
            errors++; $display("FAIL reset_req got %b exp 0000", {tx_single, tx_burst, rx_single, rx_burst}); end
        checks++; if (readdata !== 32'h0) begin
            errors++; $display("FAIL reset_readdata got %h exp 0", readdata); end
        reset = 1'b0;
        tick();
        av_read(2'd1, d);
        checks++; if (d !== 32'h0001_0000) begin
            errors++; $display("FAIL reset_status got %h exp 00010000", d); end
        av_read(2'd2, d);
        checks++; if (d !== 32'h0) begin
            errors++; $display("FAIL reset_ctrl got %h exp 0", d); end
    endtask

    task automatic test_tx_request();
        av_write(2'd2, 32'h1);
        checks++; if ({tx_single, tx_burst} !== 2'b00) begin
            errors++; $display("FAIL tx_early got %b exp 00", {tx_single, tx_burst}); end
        tick();
        checks++; if ({tx_single, tx_burst} !== 2'b11) begin
            errors++; $display("FAIL tx_req got %b exp 11", {tx_single, tx_burst}); end
        checks++; if ({rx_single, rx_burst} !== 2'b00) begin
            errors++; $display("FAIL tx_req_rx_idle got %b exp 00", {rx_single, rx_burst}); end
    endtask

    task automatic test_tx_ack();
        tx_ack = 1'b1;
        av_write(2'd2, 32'h0);
        checks++; if ({tx_single, tx_burst} !== 2'b00) begin
            errors++; $display("FAIL tx_ack_drop got %b exp 00", {tx_single, tx_burst}); end
        repeat (2) tick();
        tx_ack = 1'b0;
        repeat (3) tick();
        checks++; if ({tx_single, tx_burst} !== 2'b00) begin
            errors++; $display("FAIL tx_after_ack got %b exp 00", {tx_single, tx_burst}); end
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        tick();
        checks++; if ({tx_single, tx_burst} !== 2'b00) begin
            errors++; $display("FAIL tx_stray_ack got %b exp 00", {tx_single, tx_burst}); end
        av_write(2'd2, 32'h1);
        tick();
        checks++; if ({tx_single, tx_burst} !== 2'b11) begin
            errors++; $display("FAIL tx_rereq got %b exp 11", {tx_single, tx_burst}); end
        tx_ack = 1'b1;
        av_write(2'd2, 32'h0);
        tx_ack = 1'b0;
        repeat (2) tick();
        checks++; if ({tx_single, tx_burst} !== 2'b00) begin
            errors++; $display("FAIL tx_final_idle got %b exp 00", {tx_single, tx_burst}); end
    endtask

    task automatic test_rx_fifo();
        logic [31:0] d, e;
        av_write(2'd2, 32'h2);
        for (int i = 0; i < 7; i++) push_word($urandom);
        tick();
        checks++; if ({rx_single, rx_burst} !== 2'b10) begin
            errors++; $display("FAIL rx_single_req got %b exp 10", {rx_single, rx_burst}); end
        for (int i = 0; i < 7; i++) begin
            av_read(2'd0, d);
            e = exp_q.pop_front();
            checks++; if (d !== e) begin
                errors++; $display("FAIL rx_pop%0d got %h exp %h", i, d, e); end
        end
        rx_ack = 1'b1;
        tick();
        checks++; if ({rx_single, rx_burst} !== 2'b00) begin
            errors++; $display("FAIL rx_ack_drop got %b exp 00", {rx_single, rx_burst}); end
        rx_ack = 1'b0;
        repeat (3) tick();
        checks++; if ({rx_single, rx_burst} !== 2'b00) begin
            errors++; $display("FAIL rx_empty_idle got %b exp 00", {rx_single, rx_burst}); end
        av_write(2'd2, 32'h0);
    endtask

    task automatic test_full_ovf();
        logic [31:0] d, e;
        for (int i = 0; i < 64; i++) push_word($urandom);
        av_write(2'd0, 32'hDEAD_BEEF);
        av_read(2'd1, d);
        checks++; if (d !== 32'h0006_0040) begin
            errors++; $display("FAIL full_status got %h exp 00060040", d); end
        for (int i = 0; i < 64; i++) begin
            av_read(2'd0, d);
            e = exp_q.pop_front();
            checks++; if (d !== e) begin
                errors++; $display("FAIL full_pop%0d got %h exp %h", i, d, e); end
        end
    endtask

    task automatic test_underflow_clear();
        logic [31:0] d, e;
        av_read(2'd0, d);
        checks++; if (d !== 32'h0) begin
            errors++; $display("FAIL unf_readdata got %h exp 0", d); end
        av_read(2'd1, d);
        checks++; if (d !== 32'h000D_0000) begin
            errors++; $display("FAIL unf_status got %h exp 000d0000", d); end
        av_write(2'd2, 32'h8);
        av_write(2'd1, 32'hFFFF_FFFF);
        av_write(2'd3, 32'hFFFF_FFFF);
        av_read(2'd1, d);
        checks++; if (d !== 32'h0001_0000) begin
            errors++; $display("FAIL clr_status got %h exp 00010000", d); end
        av_read(2'd3, d);
        checks++; if (d !== 32'h0) begin
            errors++; $display("FAIL addr3_read got %h exp 0", d); end
        e = 32'hA5A5_0F0F;
        exp_q.push_back(e);
        address = 2'd0; writedata = e; write = 1'b1; read = 1'b1;
        tick();
        write = 1'b0; read = 1'b0;
        checks++; if (readdata !== 32'h0) begin
            errors++; $display("FAIL rdwr_readdata got %h exp 0", readdata); end
        av_read(2'd0, d);
        e = exp_q.pop_front();
        checks++; if (d !== e) begin
            errors++; $display("FAIL rdwr_pushed got %h exp %h", d, e); end
    endtask

    task automatic test_flush_rx();
        logic [31:0] d;
        for (int i = 0; i < 20; i++) push_word($urandom);
        av_write(2'd2, 32'h2);
        checks++; if ({rx_single, rx_burst} !== 2'b00) begin
            errors++; $display("FAIL flush_rx_early got %b exp 00", {rx_single, rx_burst}); end
        tick();
        checks++; if ({rx_single, rx_burst} !== 2'b11) begin
            errors++; $display("FAIL flush_rx_burst got %b exp 11", {rx_single, rx_burst}); end
        av_read(2'd2, d);
        checks++; if (d !== 32'h2) begin
            errors++; $display("FAIL ctrl_read got %h exp 2", d); end
        av_write(2'd2, 32'h6);
        exp_q.delete();
        av_read(2'd1, d);
        checks++; if (d !== 32'h0001_0000) begin
            errors++; $display("FAIL flush_status got %h exp 00010000", d); end
        repeat (2) tick();
        checks++; if ({rx_single, rx_burst} !== 2'b11) begin
            errors++; $display("FAIL flush_rx_held got %b exp 11", {rx_single, rx_burst}); end
        rx_ack = 1'b1;
        tick();
        checks++; if ({rx_single, rx_burst} !== 2'b00) begin
            errors++; $display("FAIL flush_rx_ack got %b exp 00", {rx_single, rx_burst}); end
        rx_ack = 1'b0;
        repeat (4) tick();
        checks++; if ({rx_single, rx_burst} !== 2'b00) begin
            errors++; $display("FAIL flush_rx_no_rereq got %b exp 00", {rx_single, rx_burst}); end
        av_write(2'd2, 32'h0);
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        av_write(2'd2, 32'h3);
        av_write(2'd0, 32'h1234_5678);
        tick();
        checks++; if ({tx_single, tx_burst, rx_single, rx_burst} !== 4'b1110) begin
            errors++; $display("FAIL both_req got %b exp 1110", {tx_single, tx_burst, rx_single, rx_burst}); end
        address = 2'd1; read = 1'b1;
        tick();
        checks++; if (readdata !== 32'h0000_0001) begin
            errors++; $display("FAIL pre_reset_status got %h exp 00000001", readdata); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({tx_single, tx_burst, rx_single, rx_burst} !== 4'b0000) begin
            errors++; $display("FAIL async_reset_req got %b exp 0000", {tx_single, tx_burst, rx_single, rx_burst}); end
        checks++; if (readdata !== 32'h0) begin
            errors++; $display("FAIL async_reset_readdata got %h exp 0", readdata); end
        read = 1'b0;
        tick();
        reset = 1'b0;
        av_read(2'd1, d);
        checks++; if (d !== 32'h0001_0000) begin
            errors++; $display("FAIL post_reset_status got %h exp 00010000", d); end
        av_read(2'd2, d);
        checks++; if (d !== 32'h0) begin
            errors++; $display("FAIL post_reset_ctrl got %h exp 0", d); end
        repeat (2) tick();
        checks++; if ({tx_single, tx_burst, rx_single, rx_burst} !== 4'b0000) begin
            errors++; $display("FAIL post_reset_req got %b exp 0000", {tx_single, tx_burst, rx_single, rx_burst}); end
    endtask

    initial begin
        test_reset();
        test_tx_request();
        test_tx_ack();
        test_rx_fifo();
        test_full_ovf();
        test_underflow_clear();
        test_flush_rx();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
